decoder_sequencer: RTL and testbench
====================================

DECODER_SEQUENCER -- requirements
Module: decoder_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd4000000, maximum cycles a stage may run before it is declared hung.
REQ-002 Clock  in  1  system clock; all state updates on rising edge.
REQ-003 Resetn  in  1  asynchronous active-low reset.
REQ-004 Start  in  1  one-cycle request to decode one image.
REQ-005 M3_enable, M2_enable, M1_enable  out  1 each  one-cycle start pulse to the lossless-decode, IDCT and colour-space/upsampling stages.
REQ-006 M3_done, M2_done, M1_done  in  1 each  one-cycle completion pulse from each stage.
REQ-007 Mx_SRAM_address  in  18, Mx_SRAM_write_data  in  16, Mx_SRAM_we_n  in  1, for x = 3, 2, 1: per-stage SRAM request buses.
REQ-008 SRAM_address  out  18, SRAM_write_data  out  16, SRAM_we_n  out  1: the shared SRAM port.
REQ-009 Busy  out  1  high from acceptance of Start until return to idle or error.
REQ-010 Done  out  1  one-cycle pulse when the full image is finished.
REQ-011 Error  out  1  sticky hang indicator.
REQ-012 Stage  out  2  current bus owner: 0 none, 1 M3, 2 M2, 3 M1.

Function
REQ-013 States: S_IDLE, S_M3_START, S_M3_RUN, S_M2_START, S_M2_RUN, S_M1_START, S_M1_RUN, S_FINISH, S_ERROR.
REQ-014 S_IDLE or S_ERROR with Start=1 -> S_M3_START next cycle, and Error clears; Start in any other state is ignored.
REQ-015 Sx_START lasts exactly one cycle: Mx_enable=1 and Stage=x in that cycle; then -> Sx_RUN.
REQ-016 Sx_RUN with Mx_done=1 -> next stage's START (M3 -> M2 -> M1 -> S_FINISH); done pulses from non-owning stages are ignored.
REQ-017 S_FINISH lasts one cycle, Done=1, Stage=0; then -> S_IDLE.
REQ-018 SRAM port is a combinational mux on the registered state: owner's address, data and we_n pass through in Sx_RUN.
REQ-019 In Sx_START, SRAM_address and SRAM_write_data come from the new owner, but SRAM_we_n is forced to 1 (guard cycle; no write across ownership change).
REQ-020 With no owner (S_IDLE, S_FINISH, S_ERROR): SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1.
REQ-021 24-bit cycle counter clears in each Sx_START and increments every Sx_RUN cycle.
REQ-022 If the counter equals TIMEOUT_CYCLES-1 in Sx_RUN and Mx_done=0 -> S_ERROR, Error=1; if Mx_done=1 in the same cycle, done wins.
REQ-023 Busy=1 in all START/RUN states, 0 in S_IDLE, S_FINISH and S_ERROR.

Reset
REQ-024 Resetn low, at any time including mid-stage: state=S_IDLE, counter=0, all enables 0, Done=0, Error=0, Busy=0, Stage=0, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0.
REQ-025 Reset release does not start a decode; Start is required.

Configuration
REQ-026 Macro LOSSLESS_DECODE_EN: when defined, sequence is M3 -> M2 -> M1 as above.
REQ-027 When LOSSLESS_DECODE_EN is not defined: S_M3_* states are absent, Start -> S_M2_START, M3_enable is tied 0, M3 inputs are ignored and Stage never reads 1.

Verification
REQ-028 Macro defined, TIMEOUT_CYCLES=16; Start; M3_done at run cycle 5, M2_done at 3, M1_done at 7 -> enable pulses M3, M2, M1 each one cycle; Stage 1,2,3,0; Done one pulse; Busy low afterwards.
REQ-029 In S_M2_RUN, M2 drives address 18'h1ABCD, data 16'h55AA, we_n 0 -> SRAM port matches; in the following S_M1_START cycle SRAM_we_n=1.
REQ-030 TIMEOUT_CYCLES=16, M2 never signals done -> Error=1 after 16 run cycles, SRAM_we_n=1, Busy=0; Start -> Error clears, S_M3_START.
REQ-031 M2_done and M1_done pulsed during S_M3_RUN -> ignored; Stage stays 1.
REQ-032 Resetn low in S_M1_RUN while M1_SRAM_we_n=0 -> SRAM_we_n=1 immediately (asynchronously), all outputs at reset values.
REQ-033 Macro undefined; Start -> first enable is M2_enable; M3_done is ignored throughout.

Source files
------------

// File: rtl/decoder_sequencer.sv
// -----------------------------------------------------------------------------
// decoder_sequencer
// Runs the image decode pipeline one stage at a time: lossless decode (M3),
// IDCT (M2), then colour-space/upsampling (M1). Each stage gets a one-cycle
// enable pulse, owns the shared SRAM port until it returns its done pulse,
// and is declared hung if it runs TIMEOUT_CYCLES cycles without finishing.
//
// Build option: define LOSSLESS_DECODE_EN to include the M3 stage. Without
// it the sequence is M2 -> M1, M3_enable_o is tied low and all M3 inputs
// are ignored.
//
// Ports
//   Clock_i, Resetn_i         system clock, async active-low reset
//   Start_i                   one-cycle request to decode one image
//   Mx_enable_o               one-cycle start pulse to stage x (x = 3,2,1)
//   Mx_done_i                 one-cycle completion pulse from stage x
//   Mx_SRAM_*_i               per-stage SRAM request bus
//   SRAM_*_o                  shared SRAM port (combinational mux)
//   Busy_o                    a stage is starting or running
//   Done_o                    one-cycle pulse when the image is finished
//   Error_o                   sticky hang indicator, cleared by Start_i
//   Stage_o                   bus owner: 0 none, 1 M3, 2 M2, 3 M1
// -----------------------------------------------------------------------------
module decoder_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000
) (
  input  logic        Clock_i,
  input  logic        Resetn_i,
  input  logic        Start_i,
  output logic        M3_enable_o,
  output logic        M2_enable_o,
  output logic        M1_enable_o,
  input  logic        M3_done_i,
  input  logic        M2_done_i,
  input  logic        M1_done_i,
  input  logic [17:0] M3_SRAM_address_i,
  input  logic [15:0] M3_SRAM_write_data_i,
  input  logic        M3_SRAM_we_n_i,
  input  logic [17:0] M2_SRAM_address_i,
  input  logic [15:0] M2_SRAM_write_data_i,
  input  logic        M2_SRAM_we_n_i,
  input  logic [17:0] M1_SRAM_address_i,
  input  logic [15:0] M1_SRAM_write_data_i,
  input  logic        M1_SRAM_we_n_i,
  output logic [17:0] SRAM_address_o,
  output logic [15:0] SRAM_write_data_o,
  output logic        SRAM_we_n_o,
  output logic        Busy_o,
  output logic        Done_o,
  output logic        Error_o,
  output logic [1:0]  Stage_o
);

  // state      | meaning
  // S_IDLE     | waiting for Start
  // S_M3_START | enable pulse to lossless decode, SRAM writes blocked
  // S_M3_RUN   | lossless decode owns SRAM, waiting for M3_done
  // S_M2_START | enable pulse to IDCT, SRAM writes blocked
  // S_M2_RUN   | IDCT owns SRAM, waiting for M2_done
  // S_M1_START | enable pulse to colour-space stage, SRAM writes blocked
  // S_M1_RUN   | colour-space stage owns SRAM, waiting for M1_done
  // S_FINISH   | Done pulse, then back to idle
  // S_ERROR    | a stage hung; Error held until the next Start
`ifdef LOSSLESS_DECODE_EN
  typedef enum logic [3:0] {
    S_IDLE, S_M3_START, S_M3_RUN, S_M2_START, S_M2_RUN,
    S_M1_START, S_M1_RUN, S_FINISH, S_ERROR
  } state_t;
  localparam state_t S_FIRST = S_M3_START;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_M2_START, S_M2_RUN, S_M1_START, S_M1_RUN, S_FINISH, S_ERROR
  } state_t;
  localparam state_t S_FIRST = S_M2_START;

  logic unused_m3;
  assign unused_m3 = ^{M3_done_i, M3_SRAM_address_i, M3_SRAM_write_data_i, M3_SRAM_we_n_i};
`endif

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        timeout;

  // Counter is zero in the first run cycle, so it reads TIMEOUT_CYCLES-1 in
  // the last cycle a stage is allowed to run.
  assign timeout = (cnt_q == TIMEOUT_CYCLES - 24'd1);

  always_ff @(posedge Clock_i or negedge Resetn_i) begin
    if (!Resetn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_ERROR: begin
        if (Start_i) state_d = S_FIRST;
      end
`ifdef LOSSLESS_DECODE_EN
      S_M3_START: begin
        state_d = S_M3_RUN;
        cnt_d   = '0;
      end
      S_M3_RUN: begin
        if (M3_done_i)    state_d = S_M2_START;
        else if (timeout) state_d = S_ERROR;
        else              cnt_d   = cnt_q + 24'd1;
      end
`endif
      S_M2_START: begin
        state_d = S_M2_RUN;
        cnt_d   = '0;
      end
      S_M2_RUN: begin
        if (M2_done_i)    state_d = S_M1_START;
        else if (timeout) state_d = S_ERROR;
        else              cnt_d   = cnt_q + 24'd1;
      end
      S_M1_START: begin
        state_d = S_M1_RUN;
        cnt_d   = '0;
      end
      S_M1_RUN: begin
        if (M1_done_i)    state_d = S_FINISH;
        else if (timeout) state_d = S_ERROR;
        else              cnt_d   = cnt_q + 24'd1;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // All outputs decode the registered state only (plus the owner's bus), so
  // an asynchronous reset forces them to their idle values immediately.
  always_comb begin
    M3_enable_o       = 1'b0;
    M2_enable_o       = 1'b0;
    M1_enable_o       = 1'b0;
    SRAM_address_o    = '0;
    SRAM_write_data_o = '0;
    SRAM_we_n_o       = 1'b1;
    Busy_o            = 1'b0;
    Done_o            = 1'b0;
    Error_o           = 1'b0;
    Stage_o           = 2'd0;
    unique case (state_q)
`ifdef LOSSLESS_DECODE_EN
      S_M3_START: begin
        M3_enable_o       = 1'b1;
        Busy_o            = 1'b1;
        Stage_o           = 2'd1;
        SRAM_address_o    = M3_SRAM_address_i;
        SRAM_write_data_o = M3_SRAM_write_data_i;
      end
      S_M3_RUN: begin
        Busy_o            = 1'b1;
        Stage_o           = 2'd1;
        SRAM_address_o    = M3_SRAM_address_i;
        SRAM_write_data_o = M3_SRAM_write_data_i;
        SRAM_we_n_o       = M3_SRAM_we_n_i;
      end
`endif
      S_M2_START: begin
        M2_enable_o       = 1'b1;
        Busy_o            = 1'b1;
        Stage_o           = 2'd2;
        SRAM_address_o    = M2_SRAM_address_i;
        SRAM_write_data_o = M2_SRAM_write_data_i;
      end
      S_M2_RUN: begin
        Busy_o            = 1'b1;
        Stage_o           = 2'd2;
        SRAM_address_o    = M2_SRAM_address_i;
        SRAM_write_data_o = M2_SRAM_write_data_i;
        SRAM_we_n_o       = M2_SRAM_we_n_i;
      end
      S_M1_START: begin
        M1_enable_o       = 1'b1;
        Busy_o            = 1'b1;
        Stage_o           = 2'd3;
        SRAM_address_o    = M1_SRAM_address_i;
        SRAM_write_data_o = M1_SRAM_write_data_i;
      end
      S_M1_RUN: begin
        Busy_o            = 1'b1;
        Stage_o           = 2'd3;
        SRAM_address_o    = M1_SRAM_address_i;
        SRAM_write_data_o = M1_SRAM_write_data_i;
        SRAM_we_n_o       = M1_SRAM_we_n_i;
      end
      S_FINISH: Done_o  = 1'b1;
      S_ERROR:  Error_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decoder_sequencer.sv
// -----------------------------------------------------------------------------
// tb_decoder_sequencer
// Randomised bench. For each image the bench picks a done delay per stage and
// expands it into the cycle-by-cycle list of phases the sequencer must walk
// through (start, run cycles, finish/error, idle). Each cycle the expected
// outputs are derived from that phase plus the random SRAM buses driven.
// -----------------------------------------------------------------------------
module tb_decoder_sequencer;

  localparam int T = 16;

  localparam logic [2:0] K_IDLE  = 3'd0;
  localparam logic [2:0] K_START = 3'd1;
  localparam logic [2:0] K_RUN   = 3'd2;
  localparam logic [2:0] K_FIN   = 3'd3;
  localparam logic [2:0] K_ERR   = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic [1:0] stg;
    logic       dn;
  } ent_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [3:1]  dn;
  logic [17:0] addr_c [1:3];
  logic [15:0] data_c [1:3];
  logic        we_c   [1:3];
  wire  [3:1]  en;
  wire  [17:0] sram_addr;
  wire  [15:0] sram_data;
  wire         sram_we_n;
  wire         busy, done, err;
  wire  [1:0]  stage;

  int          n_chk = 0;
  int          n_pass = 0;
  ent_t        tl [$];
  logic [1:0]  order [3];
  int          nst;
  bit          force_m2 = 1'b0;

  always #5 clk = ~clk;

  // Stage code c: 1 = M3, 2 = M2, 3 = M1.
  decoder_sequencer #(.TIMEOUT_CYCLES(24'd16)) dut (
    .Clock_i              (clk),
    .Resetn_i             (rstn),
    .Start_i              (start),
    .M3_enable_o          (en[1]),
    .M2_enable_o          (en[2]),
    .M1_enable_o          (en[3]),
    .M3_done_i            (dn[1]),
    .M2_done_i            (dn[2]),
    .M1_done_i            (dn[3]),
    .M3_SRAM_address_i    (addr_c[1]),
    .M3_SRAM_write_data_i (data_c[1]),
    .M3_SRAM_we_n_i       (we_c[1]),
    .M2_SRAM_address_i    (addr_c[2]),
    .M2_SRAM_write_data_i (data_c[2]),
    .M2_SRAM_we_n_i       (we_c[2]),
    .M1_SRAM_address_i    (addr_c[3]),
    .M1_SRAM_write_data_i (data_c[3]),
    .M1_SRAM_we_n_i       (we_c[3]),
    .SRAM_address_o       (sram_addr),
    .SRAM_write_data_o    (sram_data),
    .SRAM_we_n_o          (sram_we_n),
    .Busy_o               (busy),
    .Done_o               (done),
    .Error_o              (err),
    .Stage_o              (stage)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_ent(input ent_t e);
    bit   own;
    int   idx;
    own = (e.kind == K_START) || (e.kind == K_RUN);
    idx = own ? int'(e.stg) : 1;
    for (int c = 1; c <= 3; c++)
      chk($sformatf("enable%0d", c), 32'(en[c]), 32'(e.kind == K_START && int'(e.stg) == c));
    chk("stage", 32'(stage), own ? 32'(e.stg) : 32'd0);
    chk("busy",  32'(busy),  32'(own));
    chk("done",  32'(done),  32'(e.kind == K_FIN));
    chk("error", 32'(err),   32'(e.kind == K_ERR));
    chk("sram_addr", 32'(sram_addr), own ? 32'(addr_c[idx]) : 32'd0);
    chk("sram_data", 32'(sram_data), own ? 32'(data_c[idx]) : 32'd0);
    chk("sram_we_n", 32'(sram_we_n), (e.kind == K_RUN) ? 32'(we_c[idx]) : 32'd1);
  endtask

  task automatic rand_bus();
    for (int c = 1; c <= 3; c++) begin
      addr_c[c] = 18'($urandom);
      data_c[c] = 16'($urandom);
      we_c[c]   = 1'($urandom_range(0, 1));
    end
  endtask

  // Owner's done only where the plan puts it; every other done is noise.
  task automatic drive_ent(input ent_t e);
    rand_bus();
    if (force_m2 && e.kind == K_RUN && e.stg == 2'd2) begin
      addr_c[2] = 18'h1ABCD;
      data_c[2] = 16'h55AA;
      we_c[2]   = 1'b0;
    end
    for (int c = 1; c <= 3; c++)
      dn[c] = (e.kind == K_RUN && int'(e.stg) == c) ? e.dn : ($urandom_range(0, 3) == 0);
    start = (e.kind == K_START || e.kind == K_RUN || e.kind == K_FIN) ?
            ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  // Expand per-stage done delays (indexed by stage code) into the phase list.
  // A delay above T means the stage never finishes.
  task automatic build(input int d1, input int d2, input int d3);
    int dly [1:3];
    dly[1] = d1; dly[2] = d2; dly[3] = d3;
    tl.delete();
    for (int s = 0; s < nst; s++) begin
      int d;
      d = dly[order[s]];
      tl.push_back('{K_START, order[s], 1'b0});
      if (d <= T) begin
        for (int k = 1; k <= d; k++) tl.push_back('{K_RUN, order[s], (k == d)});
      end else begin
        for (int k = 1; k <= T; k++) tl.push_back('{K_RUN, order[s], 1'b0});
        tl.push_back('{K_ERR, 2'd0, 1'b0});
        return;
      end
    end
    tl.push_back('{K_FIN, 2'd0, 1'b0});
    tl.push_back('{K_IDLE, 2'd0, 1'b0});
  endtask

  // rst_k > 0: assert reset during M1 run cycle rst_k with M1 writing.
  task automatic run_image(input int d1, input int d2, input int d3, input int rst_k,
                           output logic [2:0] last_kind);
    int run_n;
    build(d1, d2, d3);
    @(negedge clk);
    rand_bus();
    for (int c = 1; c <= 3; c++) dn[c] = 1'($urandom_range(0, 1));
    start = 1'b1;
    run_n = 0;
    last_kind = K_IDLE;
    foreach (tl[i]) begin
      @(negedge clk);
      drive_ent(tl[i]);
      if (tl[i].kind == K_START) run_n = 0;
      if (tl[i].kind == K_RUN) run_n++;
      if (rst_k > 0 && tl[i].kind == K_RUN && tl[i].stg == 2'd3 && run_n == rst_k) begin
        we_c[3] = 1'b0;
        dn[3]   = 1'b0;
        #1;
        check_ent(tl[i]);
        rstn = 1'b0;
        #1;
        check_ent('{K_IDLE, 2'd0, 1'b0});
        @(negedge clk);
        check_ent('{K_IDLE, 2'd0, 1'b0});
        rstn = 1'b1;
        last_kind = K_IDLE;
        return;
      end
      #1;
      check_ent(tl[i]);
      last_kind = tl[i].kind;
    end
  endtask

  task automatic hold(input logic [2:0] kind, input int n);
    ent_t e;
    e = '{kind, 2'd0, 1'b0};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_ent(e);
      #1;
      check_ent(e);
    end
  endtask

  function automatic int pick_delay();
    if ($urandom_range(0, 9) == 0) return T + 1;
    return $urandom_range(1, T);
  endfunction

  initial begin
    logic [2:0] lk;
`ifdef LOSSLESS_DECODE_EN
    order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd3; nst = 3;
`else
    order[0] = 2'd2; order[1] = 2'd3; order[2] = 2'd0; nst = 2;
`endif
    dn = '0;
    rand_bus();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_ent('{K_IDLE, 2'd0, 1'b0});
    rstn = 1'b1;
    hold(K_IDLE, 4);

    force_m2 = 1'b1;
    run_image(5, 3, 7, 0, lk);
    force_m2 = 1'b0;
    hold(lk, 3);

    run_image(T, T, T, 0, lk);
    hold(lk, 2);

    run_image(4, T + 1, 5, 0, lk);
    hold(lk, 3);
    run_image(2, 2, 2, 0, lk);
    hold(lk, 1);

    for (int n = 0; n < 14; n++) begin
      run_image(pick_delay(), pick_delay(), pick_delay(), 0, lk);
      hold(lk, $urandom_range(0, 3));
    end

    run_image(3, 3, 10, 4, lk);
    hold(K_IDLE, 5);
    run_image(1, 1, 1, 0, lk);
    hold(lk, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
